// File: rtl/cpu_pkg.sv
// Shared decode constants and the load/store sequencer state type.
// Imported by the LSU sequencer, its lane-alignment helper and the bench.
package cpu_pkg;

    localparam logic [3:0] INST_LOAD  = 4'b0001;
    localparam logic [3:0] INST_STORE = 4'b0010;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    function automatic logic is_mem_op(input logic [3:0] inst_type);
        return (inst_type == INST_LOAD) || (inst_type == INST_STORE);
    endfunction

endpackage

// File: rtl/lsu_sequencer_if.sv
// Data-memory port between the LSU sequencer (master) and memory (slave):
// a valid/ready request channel and a single-cycle response pulse.
interface lsu_sequencer_if;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and replicated store data, load
// data shift/extension, and the illegal-width / misalignment fault flag.
module lsu_align
    import cpu_pkg::*;
(
    input  logic        i_is_load,
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_ext,
    output logic        o_fault
);

    logic [31:0] w_shift;
    logic [3:0]  w_store_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_ext;
    logic        w_fault;

    assign w_shift = i_rdata >> {i_addr_lo, 3'b000};

    // Per-width lane selection; unsigned widths only exist for loads.
    always_comb begin
        w_store_be = 4'b0000;
        w_wdata    = 32'h0000_0000;
        w_load_ext = 32'h0000_0000;
        w_fault    = 1'b0;
        case (i_func3)
            F3_B: begin
                w_store_be = 4'b0001 << i_addr_lo;
                w_wdata    = {4{i_store_data[7:0]}};
                w_load_ext = {{24{w_shift[7]}}, w_shift[7:0]};
                w_fault    = 1'b0;
            end
            F3_H: begin
                w_store_be = 4'b0011 << i_addr_lo;
                w_wdata    = {2{i_store_data[15:0]}};
                w_load_ext = {{16{w_shift[15]}}, w_shift[15:0]};
                w_fault    = i_addr_lo[0];
            end
            F3_W: begin
                w_store_be = 4'b1111;
                w_wdata    = i_store_data;
                w_load_ext = w_shift;
                w_fault    = |i_addr_lo;
            end
            F3_BU: begin
                w_load_ext = {24'h00_0000, w_shift[7:0]};
                w_fault    = ~i_is_load;
            end
            F3_HU: begin
                w_load_ext = {16'h0000, w_shift[15:0]};
                w_fault    = ~i_is_load | i_addr_lo[0];
            end
            default: begin
                w_fault = 1'b1;
            end
        endcase
    end

    assign o_be       = i_is_load ? 4'b1111 : w_store_be;
    assign o_wdata    = w_wdata;
    assign o_load_ext = w_load_ext;
    assign o_fault    = w_fault;

endmodule

// File: rtl/lsu_sequencer_chk.sv
// Protocol invariants of the LSU sequencer outputs, bound in by the top.
module lsu_sequencer_chk (
    input logic        i_clk,
    input logic        i_rst,
    input logic        i_req_valid,
    input logic        i_req_ready,
    input logic        i_we,
    input logic [31:0] i_addr,
    input logic [31:0] i_wdata,
    input logic [3:0]  i_be,
    input logic        i_done,
    input logic        i_wb_valid,
    input logic        i_mis,
    input logic        i_berr
);

    a_req_hold: assert property (@(posedge i_clk) disable iff (!i_rst)
        (i_req_valid && !i_req_ready) |=>
        (i_req_valid && $stable(i_addr) && $stable(i_wdata) && $stable(i_be) && $stable(i_we)))
        else $error("lsu: request changed before accept");

    a_flags_excl: assert property (@(posedge i_clk) disable iff (!i_rst)
        !(i_mis && i_berr))
        else $error("lsu: both fault flags set");

    a_wb_with_done: assert property (@(posedge i_clk) disable iff (!i_rst)
        (i_wb_valid || i_mis || i_berr) |-> i_done)
        else $error("lsu: completion flag without done");

endmodule

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: captures one decoded memory op, issues a single
// valid/ready request, waits (bounded) for the response and retires it.
module lsu_sequencer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [3:0]        i_inst_type,
    input  logic [2:0]        i_func3,
    input  logic [4:0]        i_rd,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_store_data,
    lsu_sequencer_if.master   mem,
    output logic              o_stall,
    output logic              o_done,
    output logic              o_wb_valid,
    output logic [4:0]        o_wb_rd,
    output logic [31:0]       o_wb_data,
    output logic              o_misaligned_fault,
    output logic              o_bus_error
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t r_state, w_state_nxt;

    logic             r_is_load, w_is_load_nxt;
    logic [2:0]       r_func3, w_func3_nxt;
    logic [4:0]       r_rd, w_rd_nxt;
    logic [1:0]       r_addr_lo, w_addr_lo_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic        r_req_valid, w_req_valid_nxt;
    logic        r_we, w_we_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [3:0]  r_be, w_be_nxt;
    logic        r_done, w_done_nxt;
    logic        r_wb_valid, w_wb_valid_nxt;
    logic [4:0]  r_wb_rd, w_wb_rd_nxt;
    logic [31:0] r_wb_data, w_wb_data_nxt;
    logic        r_mis, w_mis_nxt;
    logic        r_berr, w_berr_nxt;
    logic        w_stall;

    logic        w_in_idle;
    logic        w_al_is_load;
    logic [2:0]  w_al_func3;
    logic [1:0]  w_al_addr_lo;
    logic [3:0]  w_al_be;
    logic [31:0] w_al_wdata;
    logic [31:0] w_al_load_ext;
    logic        w_al_fault;

    // In IDLE the lane logic sees the live decode; afterwards the captured op.
    assign w_in_idle    = (r_state == IDLE);
    assign w_al_is_load = w_in_idle ? (i_inst_type == INST_LOAD) : r_is_load;
    assign w_al_func3   = w_in_idle ? i_func3 : r_func3;
    assign w_al_addr_lo = w_in_idle ? i_addr[1:0] : r_addr_lo;

    lsu_align u_align (
        .i_is_load    (w_al_is_load),
        .i_func3      (w_al_func3),
        .i_addr_lo    (w_al_addr_lo),
        .i_store_data (i_store_data),
        .i_rdata      (mem.mem_rsp_rdata),
        .o_be         (w_al_be),
        .o_wdata      (w_al_wdata),
        .o_load_ext   (w_al_load_ext),
        .o_fault      (w_al_fault)
    );

    // Next-state, capture and registered-output computation.
    always_comb begin
        w_state_nxt     = r_state;
        w_is_load_nxt   = r_is_load;
        w_func3_nxt     = r_func3;
        w_rd_nxt        = r_rd;
        w_addr_lo_nxt   = r_addr_lo;
        w_cnt_nxt       = r_cnt;
        w_req_valid_nxt = r_req_valid;
        w_we_nxt        = r_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_wdata_nxt     = r_wdata;
        w_be_nxt        = r_be;
        w_done_nxt      = 1'b0;
        w_wb_valid_nxt  = 1'b0;
        w_wb_rd_nxt     = r_wb_rd;
        w_wb_data_nxt   = r_wb_data;
        w_mis_nxt       = 1'b0;
        w_berr_nxt      = 1'b0;
        w_stall         = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start && is_mem_op(i_inst_type)) begin
                    w_stall       = 1'b1;
                    w_is_load_nxt = (i_inst_type == INST_LOAD);
                    w_func3_nxt   = i_func3;
                    w_rd_nxt      = i_rd;
                    w_addr_lo_nxt = i_addr[1:0];
                    if (w_al_fault) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                        w_mis_nxt   = 1'b1;
                    end else begin
                        w_state_nxt     = REQ;
                        w_req_valid_nxt = 1'b1;
                        w_we_nxt        = (i_inst_type == INST_STORE);
                        w_mem_addr_nxt  = {i_addr[31:2], 2'b00};
                        w_wdata_nxt     = w_al_wdata;
                        w_be_nxt        = w_al_be;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                w_stall = 1'b1;
                if (mem.mem_req_ready) begin
                    w_state_nxt     = WAIT;
                    w_req_valid_nxt = 1'b0;
                    w_cnt_nxt       = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = REQ;
                end
            end
            WAIT: begin
                w_stall = 1'b1;
                if (mem.mem_rsp_valid) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                    if (r_is_load && (r_rd != 5'd0)) begin
                        w_wb_valid_nxt = 1'b1;
                        w_wb_rd_nxt    = r_rd;
                        w_wb_data_nxt  = w_al_load_ext;
                    end else begin
                        w_wb_valid_nxt = 1'b0;
                    end
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                    w_berr_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_is_load   <= 1'b0;
            r_func3     <= 3'b000;
            r_rd        <= 5'd0;
            r_addr_lo   <= 2'b00;
            r_cnt       <= {CNT_W{1'b0}};
            r_req_valid <= 1'b0;
            r_we        <= 1'b0;
            r_mem_addr  <= 32'h0000_0000;
            r_wdata     <= 32'h0000_0000;
            r_be        <= 4'b0000;
            r_done      <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= 32'h0000_0000;
            r_mis       <= 1'b0;
            r_berr      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_is_load   <= w_is_load_nxt;
            r_func3     <= w_func3_nxt;
            r_rd        <= w_rd_nxt;
            r_addr_lo   <= w_addr_lo_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_valid <= w_req_valid_nxt;
            r_we        <= w_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_be        <= w_be_nxt;
            r_done      <= w_done_nxt;
            r_wb_valid  <= w_wb_valid_nxt;
            r_wb_rd     <= w_wb_rd_nxt;
            r_wb_data   <= w_wb_data_nxt;
            r_mis       <= w_mis_nxt;
            r_berr      <= w_berr_nxt;
        end
    end

    assign mem.mem_req_valid  = r_req_valid;
    assign mem.mem_we         = r_we;
    assign mem.mem_addr       = r_mem_addr;
    assign mem.mem_wdata      = r_wdata;
    assign mem.mem_be         = r_be;
    assign o_stall            = w_stall;
    assign o_done             = r_done;
    assign o_wb_valid         = r_wb_valid;
    assign o_wb_rd            = r_wb_rd;
    assign o_wb_data          = r_wb_data;
    assign o_misaligned_fault = r_mis;
    assign o_bus_error        = r_berr;

    lsu_sequencer_chk u_chk (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (r_req_valid),
        .i_req_ready (mem.mem_req_ready),
        .i_we        (r_we),
        .i_addr      (r_mem_addr),
        .i_wdata     (r_wdata),
        .i_be        (r_be),
        .i_done      (r_done),
        .i_wb_valid  (r_wb_valid),
        .i_mis       (r_mis),
        .i_berr      (r_berr)
    );

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed table-driven bench for lsu_sequencer plus hand-written sequences
// for timeout, ignored late responses and reset in the middle of an op.
module tb_lsu_sequencer;
    import cpu_pkg::*;

    typedef struct {
        logic [3:0]  it;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          delay;
        logic        exp_fault;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic        exp_wbv;
        logic [31:0] exp_wbd;
    } vec_t;

    localparam int NV = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  inst_type = 4'b0000;
    logic [2:0]  func3 = 3'b000;
    logic [4:0]  rd = 5'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        stall, done, wb_valid, mis, berr;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[NV];

    lsu_sequencer_if bus ();

    lsu_sequencer #(.TIMEOUT_CYCLES(4), .CNT_W(10)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_start            (start),
        .i_inst_type        (inst_type),
        .i_func3            (func3),
        .i_rd               (rd),
        .i_addr             (addr),
        .i_store_data       (store_data),
        .mem                (bus.master),
        .o_stall            (stall),
        .o_done             (done),
        .o_wb_valid         (wb_valid),
        .o_wb_rd            (wb_rd),
        .o_wb_data          (wb_data),
        .o_misaligned_fault (mis),
        .o_bus_error        (berr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input string tag, input vec_t v);
        chk({tag, " req_valid"}, {31'd0, bus.mem_req_valid}, 32'd1);
        chk({tag, " addr"}, bus.mem_addr, v.addr & 32'hFFFF_FFFC);
        chk({tag, " be"}, {28'd0, bus.mem_be}, {28'd0, v.exp_be});
        chk({tag, " we"}, {31'd0, bus.mem_we}, {31'd0, v.exp_we});
        if (v.exp_we) chk({tag, " wdata"}, bus.mem_wdata, v.exp_wdata);
        chk({tag, " stall"}, {31'd0, stall}, 32'd1);
    endtask

    task automatic run_vec(input int idx);
        vec_t  v;
        string tag;
        v   = vecs[idx];
        tag = $sformatf("v%0d", idx);
        start = 1'b1; inst_type = v.it; func3 = v.f3; rd = v.rd;
        addr = v.addr; store_data = v.sdata;
        #1;
        chk({tag, " stall@T"}, {31'd0, stall}, 32'd1);
        step();
        start = 1'b0;
        if (v.exp_fault) begin
            chk({tag, " done@T+1"}, {31'd0, done}, 32'd1);
            chk({tag, " mis@T+1"}, {31'd0, mis}, 32'd1);
            chk({tag, " no_req"}, {31'd0, bus.mem_req_valid}, 32'd0);
            chk({tag, " no_wb"}, {31'd0, wb_valid}, 32'd0);
            chk({tag, " stall_done"}, {31'd0, stall}, 32'd0);
        end else begin
            chk_req({tag, " T+1"}, v);
            for (int k = 0; k < v.delay; k++) begin
                step();
                chk_req($sformatf("%s hold%0d", tag, k), v);
            end
            bus.mem_req_ready = 1'b1;
            step();
            bus.mem_req_ready = 1'b0;
            chk({tag, " req_dropped"}, {31'd0, bus.mem_req_valid}, 32'd0);
            chk({tag, " stall_wait"}, {31'd0, stall}, 32'd1);
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_rdata = v.rdata;
            step();
            bus.mem_rsp_valid = 1'b0;
            chk({tag, " done"}, {31'd0, done}, 32'd1);
            chk({tag, " wb_valid"}, {31'd0, wb_valid}, {31'd0, v.exp_wbv});
            if (v.exp_wbv) begin
                chk({tag, " wb_data"}, wb_data, v.exp_wbd);
                chk({tag, " wb_rd"}, {27'd0, wb_rd}, {27'd0, v.rd});
            end
            chk({tag, " mis_clr"}, {31'd0, mis}, 32'd0);
            chk({tag, " berr_clr"}, {31'd0, berr}, 32'd0);
            chk({tag, " stall_done"}, {31'd0, stall}, 32'd0);
        end
        step();
        chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " req_valid"}, {31'd0, bus.mem_req_valid}, 32'd0);
        chk({tag, " we"}, {31'd0, bus.mem_we}, 32'd0);
        chk({tag, " addr"}, bus.mem_addr, 32'd0);
        chk({tag, " wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, " be"}, {28'd0, bus.mem_be}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " wb_valid"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, " wb_rd"}, {27'd0, wb_rd}, 32'd0);
        chk({tag, " wb_data"}, wb_data, 32'd0);
        chk({tag, " mis"}, {31'd0, mis}, 32'd0);
        chk({tag, " berr"}, {31'd0, berr}, 32'd0);
        chk({tag, " stall"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'h0;

        vecs[0]  = '{INST_LOAD,  F3_W,   5'd5, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        vecs[1]  = '{INST_LOAD,  F3_B,   5'd6, 32'h203, 32'h0,        32'h80112233, 0, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'hFFFFFF80};
        vecs[2]  = '{INST_LOAD,  F3_BU,  5'd6, 32'h203, 32'h0,        32'h80112233, 0, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'h00000080};
        vecs[3]  = '{INST_STORE, F3_H,   5'd0, 32'h302, 32'h0000ABCD, 32'h0,        3, 1'b0, 4'hC, 32'hABCDABCD, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{INST_LOAD,  F3_W,   5'd5, 32'h101, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[5]  = '{INST_LOAD,  F3_H,   5'd7, 32'h102, 32'h0,        32'h80112233, 1, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'hFFFF8011};
        vecs[6]  = '{INST_LOAD,  F3_HU,  5'd7, 32'h102, 32'h0,        32'h80112233, 0, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'h00008011};
        vecs[7]  = '{INST_STORE, F3_B,   5'd0, 32'h401, 32'h12345678, 32'h0,        0, 1'b0, 4'h2, 32'h78787878, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{INST_STORE, F3_W,   5'd0, 32'h500, 32'hCAFEF00D, 32'h0,        2, 1'b0, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{INST_LOAD,  F3_W,   5'd0, 32'h010, 32'h0,        32'h11111111, 0, 1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[10] = '{INST_LOAD,  F3_H,   5'd3, 32'h103, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[11] = '{INST_LOAD,  3'b011, 5'd3, 32'h000, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[12] = '{INST_STORE, F3_BU,  5'd0, 32'h000, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[13] = '{INST_STORE, F3_W,   5'd0, 32'h502, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,        1'b0, 1'b0, 32'h0};

        // Reset state.
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b1;
        step();

        // Non-memory instruction: no stall, no activity.
        start = 1'b1; inst_type = 4'b0100; func3 = F3_W; addr = 32'h100;
        #1;
        chk("other_type stall", {31'd0, stall}, 32'd0);
        step();
        start = 1'b0;
        chk("other_type req", {31'd0, bus.mem_req_valid}, 32'd0);
        chk("other_type done", {31'd0, done}, 32'd0);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Timeout: accepted load, no response.
        start = 1'b1; inst_type = INST_LOAD; func3 = F3_W; rd = 5'd3; addr = 32'h20;
        step();
        start = 1'b0;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        for (int k = 1; k < 4; k++) begin
            step();
            chk($sformatf("to wait%0d done", k), {31'd0, done}, 32'd0);
            chk($sformatf("to wait%0d stall", k), {31'd0, stall}, 32'd1);
        end
        step();
        chk("to done", {31'd0, done}, 32'd1);
        chk("to berr", {31'd0, berr}, 32'd1);
        chk("to mis", {31'd0, mis}, 32'd0);
        chk("to wb_valid", {31'd0, wb_valid}, 32'd0);
        step();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h12345678;
        step();
        bus.mem_rsp_valid = 1'b0;
        chk("late_rsp done", {31'd0, done}, 32'd0);
        chk("late_rsp wb", {31'd0, wb_valid}, 32'd0);
        step();
        chk("late_rsp done2", {31'd0, done}, 32'd0);

        // Reset asserted while waiting for a response.
        start = 1'b1; inst_type = INST_LOAD; func3 = F3_W; rd = 5'd9; addr = 32'h40;
        step();
        start = 1'b0;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk_all_zero("rst_wait");
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'hA5A5A5A5;
        step();
        bus.mem_rsp_valid = 1'b0;
        chk("rst_rsp done", {31'd0, done}, 32'd0);
        chk("rst_rsp wb", {31'd0, wb_valid}, 32'd0);
        step();
        chk("rst_rsp done2", {31'd0, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
